// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction
// memory, and loads the IF/ID register with the fetched word or a bubble.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_PC   = 32'h8000_0004,
  parameter logic [31:0] EXC_PC   = 32'h8000_0008,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] epc
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcPlus4_q, pcPlus4_d;
  logic        valid_q, valid_d;

  logic [31:0] seqPc;
  logic        irqTake;
  logic        bubble;

  // Sequential flow keeps the supervisor bit and wraps the low 31 bits.
  assign seqPc   = {pc_q[31], pc_q[30:0] + 31'd4};
  assign irqTake = irq & ~pc_q[31] & ~exc;
  assign bubble  = exc | irqTake | redirect_valid | flush;

  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    instr_d   = instr_q;
    pcPlus4_d = pcPlus4_q;
    valid_d   = valid_q;

    if (exc) begin
      pc_d  = EXC_PC;
      epc_d = pcPlus4_q;
    end else if (irqTake) begin
      pc_d  = IRQ_PC;
      epc_d = seqPc;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (!stall) begin
      pc_d = seqPc;
    end

    // A redirect or trap wins over stall: ID has already consumed its word.
    if (bubble) begin
      instr_d   = NOP;
      pcPlus4_d = seqPc;
      valid_d   = 1'b0;
    end else if (!stall) begin
      instr_d   = imem_instr;
      pcPlus4_d = seqPc;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      epc_q     <= 32'h0;
      instr_q   <= NOP;
      pcPlus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      instr_q   <= instr_d;
      pcPlus4_q <= pcPlus4_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign epc            = epc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pcPlus4_q;
  assign if_id_valid    = valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus pushes the expected post-edge
// state, a monitor pops and compares it shortly after each rising edge.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall, flush, redirect_valid, irq, exc;
  logic [31:0] redirect_pc;
  logic [31:0] pc, if_id_instr, if_id_pc_plus4, epc;
  logic        if_id_valid;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] epc;
  } exp_t;

  exp_t expQ[$];

  inst_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq            (irq),
    .exc            (exc),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .epc            (epc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = memWord(imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
  endtask

  task automatic checkAll(input exp_t e);
    checkOutput({e.name, ".pc"}, pc, e.pc);
    checkOutput({e.name, ".imem_addr"}, imem_addr, e.pc);
    checkOutput({e.name, ".instr"}, if_id_instr, e.instr);
    checkOutput({e.name, ".pc4"}, if_id_pc_plus4, e.pc4);
    checkOutput({e.name, ".valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
    checkOutput({e.name, ".epc"}, epc, e.epc);
  endtask

  // Called at posedge+4: drive inputs for the coming edge and queue the
  // state expected after it.
  task automatic applyStimulus(input string name, input logic st, input logic fl,
                               input logic rv, input logic [31:0] rpc,
                               input logic iq, input logic ex,
                               input logic [31:0] ePc, input logic [31:0] eInstr,
                               input logic [31:0] ePc4, input logic eValid,
                               input logic [31:0] eEpc);
    exp_t e;
    stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    irq = iq; exc = ex;
    e.name = name; e.pc = ePc; e.instr = eInstr; e.pc4 = ePc4;
    e.valid = eValid; e.epc = eEpc;
    expQ.push_back(e);
    @(posedge clk);
    #4;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) checkAll(expQ.pop_front());
    end
  end

  initial begin
    exp_t r;
    reset = 1'b1;
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0; irq = 0; exc = 0;
    @(posedge clk);
    #4;
    r.name = "reset"; r.pc = 32'h8000_0000; r.instr = 32'h0; r.pc4 = 32'h0;
    r.valid = 1'b0; r.epc = 32'h0;
    checkAll(r);
    reset = 1'b0;

    applyStimulus("seq1", 0,0,0,0,0,0, 32'h8000_0004, memWord(32'h8000_0000), 32'h8000_0004, 1, 0);
    applyStimulus("seq2", 0,0,0,0,0,0, 32'h8000_0008, memWord(32'h8000_0004), 32'h8000_0008, 1, 0);
    applyStimulus("seq3", 0,0,0,0,0,0, 32'h8000_000C, memWord(32'h8000_0008), 32'h8000_000C, 1, 0);

    applyStimulus("redir0c", 0,0,1,32'h0040_000C,0,0, 32'h0040_000C, 32'h0, 32'h8000_0010, 0, 0);
    applyStimulus("fetch0c", 0,0,0,0,0,0, 32'h0040_0010, memWord(32'h0040_000C), 32'h0040_0010, 1, 0);
    applyStimulus("stall1", 1,0,0,0,0,0, 32'h0040_0010, memWord(32'h0040_000C), 32'h0040_0010, 1, 0);
    applyStimulus("stall2", 1,0,0,0,0,0, 32'h0040_0010, memWord(32'h0040_000C), 32'h0040_0010, 1, 0);
    applyStimulus("unstall", 0,0,0,0,0,0, 32'h0040_0014, memWord(32'h0040_0010), 32'h0040_0014, 1, 0);

    applyStimulus("redirStall", 1,0,1,32'h0040_006C,0,0, 32'h0040_006C, 32'h0, 32'h0040_0018, 0, 0);
    applyStimulus("fetch6c", 0,0,0,0,0,0, 32'h0040_0070, memWord(32'h0040_006C), 32'h0040_0070, 1, 0);

    applyStimulus("redir20", 0,0,1,32'h0040_0020,0,0, 32'h0040_0020, 32'h0, 32'h0040_0074, 0, 0);
    applyStimulus("irqTake", 0,0,0,0,1,0, 32'h8000_0004, 32'h0, 32'h0040_0024, 0, 32'h0040_0024);
    applyStimulus("irqMasked", 0,0,0,0,1,0, 32'h8000_0008, memWord(32'h8000_0004), 32'h8000_0008, 1, 32'h0040_0024);

    applyStimulus("redir30", 0,0,1,32'h0040_0030,0,0, 32'h0040_0030, 32'h0, 32'h8000_000C, 0, 32'h0040_0024);
    applyStimulus("fetch30", 0,0,0,0,0,0, 32'h0040_0034, memWord(32'h0040_0030), 32'h0040_0034, 1, 32'h0040_0024);
    applyStimulus("excIrq", 0,0,0,0,1,1, 32'h8000_0008, 32'h0, 32'h0040_0038, 0, 32'h0040_0034);

    applyStimulus("flush", 0,1,0,0,0,0, 32'h8000_000C, 32'h0, 32'h8000_000C, 0, 32'h0040_0034);
    applyStimulus("flushStall", 1,1,0,0,0,0, 32'h8000_000C, 32'h0, 32'h8000_0010, 0, 32'h0040_0034);

    applyStimulus("redir7ffc", 0,0,1,32'h7FFF_FFFC,0,0, 32'h7FFF_FFFC, 32'h0, 32'h8000_0010, 0, 32'h0040_0034);
    applyStimulus("wrapUser", 0,0,0,0,0,0, 32'h0000_0000, memWord(32'h7FFF_FFFC), 32'h0000_0000, 1, 32'h0040_0034);
    applyStimulus("redirfffc", 0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0004, 0, 32'h0040_0034);
    applyStimulus("wrapSuper", 0,0,0,0,0,0, 32'h8000_0000, memWord(32'hFFFF_FFFC), 32'h8000_0000, 1, 32'h0040_0034);

    // Mid-cycle reset during a redirect must take effect without a clock edge.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1234_5678;
    #1 reset = 1'b1;
    #1;
    r.name = "asyncReset"; r.pc = 32'h8000_0000; r.instr = 32'h0; r.pc4 = 32'h0;
    r.valid = 1'b0; r.epc = 32'h0;
    checkAll(r);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clk);
    #4;
    reset = 1'b0;
    applyStimulus("postReset", 0,0,0,0,0,0, 32'h8000_0004, memWord(32'h8000_0000), 32'h8000_0004, 1, 0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #4;
    checkCount++;
    if (expQ.size() == 0) passCount++;
    else $display("[TB] FAIL drain actual=%0d expected=0 pending", expQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
